// File: rtl/guess_pkg.sv
// Shared constants, state encoding and helpers for the guess entry controller.
// Slot colours are 3-bit codes: 0 = off, 1..NUM_COLORS selectable, 7 reserved.
package guess_pkg;

    localparam int          SLOTS      = 4;
    localparam int          SLOT_W     = 3;
    localparam int          CODE_W     = SLOTS * SLOT_W;

    localparam logic [SLOT_W-1:0] COLOR_OFF = 3'd0;
    localparam logic [SLOT_W-1:0] COLOR_MIN = 3'd1;
    localparam logic [SLOT_W-1:0] FB_EXACT  = 3'b010;

    typedef enum logic [1:0] {
        ST_EDIT    = 2'd0,
        ST_SUBMIT  = 2'd1,
        ST_WAIT_FB = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // True when every feedback field reports an exact colour+position hit.
    function automatic logic all_exact(input logic [CODE_W-1:0] fb);
        logic hit;
        hit = 1'b1;
        for (int i = 0; i < SLOTS; i++) begin
            if (fb[i*SLOT_W +: SLOT_W] != FB_EXACT) begin
                hit = 1'b0;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/guess_entry_wrap_step.sv
// Wrapping increment/decrement over the closed range [LO, HI].
// dec has priority over inc; with neither asserted the value passes through.
module wrap_step #(
    parameter int W  = 3,
    parameter int LO = 1,
    parameter int HI = 6
) (
    input  logic [W-1:0] value,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] next
);

    localparam logic [W-1:0] LO_V  = W'(LO);
    localparam logic [W-1:0] HI_V  = W'(HI);
    localparam logic [W-1:0] ONE_V = W'(1);

    always_comb begin
        next = value;
        if (dec) begin
            next = (value == LO_V) ? HI_V : value - ONE_V;
        end else if (inc) begin
            next = (value == HI_V) ? LO_V : value + ONE_V;
        end
    end

endmodule

// File: rtl/guess_entry.sv
// Player-side guess entry: button-driven 4-slot colour editor, valid/ready hand-off
// to the scorer, feedback latch and guess/win bookkeeping. All outputs registered.
//
// state      | meaning
// ST_EDIT    | player edits slots, cursor blinks
// ST_SUBMIT  | guess offered to scorer, held until accepted
// ST_WAIT_FB | waiting for scorer feedback strobe
// ST_DONE    | game finished, outputs frozen until btn_submit
module guess_entry
    import guess_pkg::*;
#(
    parameter int NUM_COLORS  = 6,
    parameter int MAX_GUESSES = 10,
    parameter int CNT_W       = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_left,
    input  logic              btn_right,
    input  logic              btn_up,
    input  logic              btn_down,
    input  logic              btn_submit,
    input  logic              guess_ready,
    input  logic              feedback_valid,
    input  logic [CODE_W-1:0] feedback_rgb,
    output logic              guess_valid,
    output logic [CODE_W-1:0] guess_code,
    output logic              blink_enable,
    output logic [1:0]        blink_led,
    output logic [SLOT_W-1:0] guess_rgb0,
    output logic [SLOT_W-1:0] guess_rgb1,
    output logic [SLOT_W-1:0] guess_rgb2,
    output logic [SLOT_W-1:0] guess_rgb3,
    output logic [SLOT_W-1:0] history_rgb0,
    output logic [SLOT_W-1:0] history_rgb1,
    output logic [SLOT_W-1:0] history_rgb2,
    output logic [SLOT_W-1:0] history_rgb3,
    output logic [CNT_W-1:0]  guess_count,
    output logic              game_over,
    output logic              game_won
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_GUESSES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t            state_q;
    logic [SLOT_W-1:0] slot_q [SLOTS];
    logic [SLOT_W-1:0] hist_q [SLOTS];
    logic [1:0]        cur_q;
    logic              valid_q;
    logic              blink_en_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              over_q;
    logic              won_q;

    logic              act_left;
    logic              act_right;
    logic              act_up;
    logic              act_down;
    logic [1:0]        cur_d;
    logic [SLOT_W-1:0] color_d;
    logic              new_game;

    // One action per cycle: submit > left > right > up > down.
    always_comb begin
        act_left  = btn_left && !btn_submit;
        act_right = btn_right && !btn_submit && !btn_left;
        act_up    = btn_up && !btn_submit && !btn_left && !btn_right;
        act_down  = btn_down && !btn_submit && !btn_left && !btn_right && !btn_up;
    end

    wrap_step #(
        .W  (2),
        .LO (0),
        .HI (SLOTS - 1)
    ) u_cursor_step (
        .value (cur_q),
        .inc   (act_right),
        .dec   (act_left),
        .next  (cur_d)
    );

    wrap_step #(
        .W  (SLOT_W),
        .LO (1),
        .HI (NUM_COLORS)
    ) u_color_step (
        .value (slot_q[cur_q]),
        .inc   (act_up),
        .dec   (act_down),
        .next  (color_d)
    );

    // A submit press in DONE starts a new game with exactly the reset values.
    assign new_game = (state_q == ST_DONE) && btn_submit;

    always_ff @(posedge clk) begin
        if (!rst_n || new_game) begin
            state_q    <= ST_EDIT;
            cur_q      <= 2'd0;
            valid_q    <= 1'b0;
            blink_en_q <= 1'b1;
            cnt_q      <= '0;
            over_q     <= 1'b0;
            won_q      <= 1'b0;
            for (int i = 0; i < SLOTS; i++) begin
                slot_q[i] <= COLOR_MIN;
                hist_q[i] <= COLOR_OFF;
            end
        end else begin
            case (state_q)
                ST_EDIT: begin
                    if (btn_submit) begin
                        state_q    <= ST_SUBMIT;
                        valid_q    <= 1'b1;
                        blink_en_q <= 1'b0;
                    end else begin
                        cur_q         <= cur_d;
                        slot_q[cur_q] <= color_d;
                    end
                end
                ST_SUBMIT: begin
                    if (guess_ready) begin
                        state_q <= ST_WAIT_FB;
                        valid_q <= 1'b0;
                        if (cnt_q != CNT_MAX) begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                end
                ST_WAIT_FB: begin
                    if (feedback_valid) begin
                        for (int i = 0; i < SLOTS; i++) begin
                            hist_q[i] <= feedback_rgb[i*SLOT_W +: SLOT_W];
                        end
                        if (all_exact(feedback_rgb)) begin
                            state_q <= ST_DONE;
                            over_q  <= 1'b1;
                            won_q   <= 1'b1;
                        end else if (cnt_q == CNT_MAX) begin
                            state_q <= ST_DONE;
                            over_q  <= 1'b1;
                            won_q   <= 1'b0;
                        end else begin
                            state_q    <= ST_EDIT;
                            cur_q      <= 2'd0;
                            blink_en_q <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    over_q     <= 1'b1;
                    blink_en_q <= 1'b0;
                end
                default: begin
                    state_q <= ST_EDIT;
                end
            endcase
        end
    end

    assign guess_valid  = valid_q;
    assign blink_enable = blink_en_q;
    assign blink_led    = cur_q;
    assign guess_count  = cnt_q;
    assign game_over    = over_q;
    assign game_won     = won_q;

    assign guess_rgb0   = slot_q[0];
    assign guess_rgb1   = slot_q[1];
    assign guess_rgb2   = slot_q[2];
    assign guess_rgb3   = slot_q[3];
    assign guess_code   = {slot_q[3], slot_q[2], slot_q[1], slot_q[0]};

    assign history_rgb0 = hist_q[0];
    assign history_rgb1 = hist_q[1];
    assign history_rgb2 = hist_q[2];
    assign history_rgb3 = hist_q[3];

endmodule

// File: tb/tb_guess_entry.sv
// Bench for guess_entry: directed vector table, hand sequences for the handshake,
// win/lose and reset corners, then random play against a game-rule reference model.
module tb_guess_entry;

    localparam int NC   = 6;
    localparam int MAXG = 10;

    localparam logic [4:0] B_NONE = 5'b00000;
    localparam logic [4:0] B_SUB  = 5'b10000;
    localparam logic [4:0] B_L    = 5'b01000;
    localparam logic [4:0] B_R    = 5'b00100;
    localparam logic [4:0] B_U    = 5'b00010;
    localparam logic [4:0] B_D    = 5'b00001;

    localparam int P_EDIT = 0;
    localparam int P_SUB  = 1;
    localparam int P_WAIT = 2;
    localparam int P_DONE = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        btn_left = 1'b0, btn_right = 1'b0, btn_up = 1'b0, btn_down = 1'b0, btn_submit = 1'b0;
    logic        guess_ready = 1'b0;
    logic        feedback_valid = 1'b0;
    logic [11:0] feedback_rgb = 12'd0;
    logic        guess_valid;
    logic [11:0] guess_code;
    logic        blink_enable;
    logic [1:0]  blink_led;
    logic [2:0]  guess_rgb0, guess_rgb1, guess_rgb2, guess_rgb3;
    logic [2:0]  history_rgb0, history_rgb1, history_rgb2, history_rgb3;
    logic [3:0]  guess_count;
    logic        game_over;
    logic        game_won;

    int errors = 0;
    int checks = 0;

    guess_entry #(
        .NUM_COLORS  (NC),
        .MAX_GUESSES (MAXG),
        .CNT_W       (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .btn_left       (btn_left),
        .btn_right      (btn_right),
        .btn_up         (btn_up),
        .btn_down       (btn_down),
        .btn_submit     (btn_submit),
        .guess_ready    (guess_ready),
        .feedback_valid (feedback_valid),
        .feedback_rgb   (feedback_rgb),
        .guess_valid    (guess_valid),
        .guess_code     (guess_code),
        .blink_enable   (blink_enable),
        .blink_led      (blink_led),
        .guess_rgb0     (guess_rgb0),
        .guess_rgb1     (guess_rgb1),
        .guess_rgb2     (guess_rgb2),
        .guess_rgb3     (guess_rgb3),
        .history_rgb0   (history_rgb0),
        .history_rgb1   (history_rgb1),
        .history_rgb2   (history_rgb2),
        .history_rgb3   (history_rgb3),
        .guess_count    (guess_count),
        .game_over      (game_over),
        .game_won       (game_won)
    );

    always #5 clk = ~clk;

    // Reference model: game rules with plain integer arithmetic.
    int m_phase, m_cur, m_cnt;
    int m_slot [4];
    int m_hist [4];
    bit m_gv, m_over, m_won;

    task automatic model_reset();
        m_phase = P_EDIT;
        m_cur   = 0;
        m_cnt   = 0;
        m_gv    = 1'b0;
        m_over  = 1'b0;
        m_won   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_slot[i] = 1;
            m_hist[i] = 0;
        end
    endtask

    task automatic model_step(input logic [4:0] b, input logic rdy, input logic fbv,
                              input logic [11:0] fb, input logic rst);
        bit exact;
        if (rst) begin
            model_reset();
        end else begin
            case (m_phase)
                P_EDIT: begin
                    if (b[4]) begin
                        m_phase = P_SUB;
                        m_gv    = 1'b1;
                    end else if (b[3]) m_cur = (m_cur + 3) % 4;
                    else if (b[2]) m_cur = (m_cur + 1) % 4;
                    else if (b[1]) m_slot[m_cur] = m_slot[m_cur] % NC + 1;
                    else if (b[0]) m_slot[m_cur] = (m_slot[m_cur] + NC - 2) % NC + 1;
                end
                P_SUB: begin
                    if (rdy) begin
                        m_phase = P_WAIT;
                        m_gv    = 1'b0;
                        if (m_cnt < MAXG) m_cnt = m_cnt + 1;
                    end
                end
                P_WAIT: begin
                    if (fbv) begin
                        exact = 1'b1;
                        for (int i = 0; i < 4; i++) begin
                            m_hist[i] = int'(fb[3*i +: 3]);
                            if (m_hist[i] != 2) exact = 1'b0;
                        end
                        if (exact) begin
                            m_phase = P_DONE;
                            m_over  = 1'b1;
                            m_won   = 1'b1;
                        end else if (m_cnt == MAXG) begin
                            m_phase = P_DONE;
                            m_over  = 1'b1;
                        end else begin
                            m_phase = P_EDIT;
                            m_cur   = 0;
                        end
                    end
                end
                default: begin
                    if (b[4]) model_reset();
                end
            endcase
        end
    endtask

    function automatic logic [63:0] model_vec();
        return {30'd0, m_gv,
                3'(m_slot[3]), 3'(m_slot[2]), 3'(m_slot[1]), 3'(m_slot[0]),
                (m_phase == P_EDIT), 2'(m_cur),
                3'(m_hist[3]), 3'(m_hist[2]), 3'(m_hist[1]), 3'(m_hist[0]),
                4'(m_cnt), m_over, m_won};
    endfunction

    function automatic logic [63:0] dut_vec();
        return {30'd0, guess_valid, guess_code, blink_enable, blink_led,
                history_rgb3, history_rgb2, history_rgb1, history_rgb0,
                guess_count, game_over, game_won};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance model, then compare the whole output set.
    task automatic step(input logic [4:0] b, input logic rdy, input logic fbv,
                        input logic [11:0] fb, input logic rst);
        btn_submit     = b[4];
        btn_left       = b[3];
        btn_right      = b[2];
        btn_up         = b[1];
        btn_down       = b[0];
        guess_ready    = rdy;
        feedback_valid = fbv;
        feedback_rgb   = fb;
        rst_n          = ~rst;
        @(posedge clk);
        model_step(b, rdy, fbv, fb, rst);
        #1;
        {btn_submit, btn_left, btn_right, btn_up, btn_down} = 5'b0;
        guess_ready    = 1'b0;
        feedback_valid = 1'b0;
        rst_n          = 1'b1;
        chk("model", dut_vec(), model_vec());
    endtask

    typedef struct {
        logic [4:0]  b;
        logic        rdy;
        logic [1:0]  bl;
        logic [11:0] code;
        logic        be;
        logic        gv;
    } vec_t;

    vec_t tbl [9];

    initial begin
        tbl[0] = '{B_L,             1'b0, 2'd3, 12'o1111, 1'b1, 1'b0};
        tbl[1] = '{B_D,             1'b0, 2'd3, 12'o6111, 1'b1, 1'b0};
        tbl[2] = '{B_U,             1'b0, 2'd3, 12'o1111, 1'b1, 1'b0};
        tbl[3] = '{B_L | B_U,       1'b0, 2'd2, 12'o1111, 1'b1, 1'b0};
        tbl[4] = '{B_R | B_U | B_D, 1'b0, 2'd3, 12'o1111, 1'b1, 1'b0};
        tbl[5] = '{B_U | B_D,       1'b0, 2'd3, 12'o2111, 1'b1, 1'b0};
        tbl[6] = '{B_D,             1'b0, 2'd3, 12'o1111, 1'b1, 1'b0};
        tbl[7] = '{B_SUB | B_R,     1'b1, 2'd3, 12'o1111, 1'b0, 1'b1};
        tbl[8] = '{B_U,             1'b1, 2'd3, 12'o1111, 1'b0, 1'b0};

        model_reset();
        step(B_NONE, 1'b0, 1'b0, 12'd0, 1'b1);
        chk("reset_outputs", dut_vec(),
            {30'd0, 1'b0, 12'o1111, 1'b1, 2'd0, 12'o0000, 4'd0, 1'b0, 1'b0});

        for (int i = 0; i < 9; i++) begin
            step(tbl[i].b, tbl[i].rdy, 1'b0, 12'd0, 1'b0);
            chk($sformatf("vec%0d", i), {48'd0, blink_led, guess_code, blink_enable, guess_valid},
                {48'd0, tbl[i].bl, tbl[i].code, tbl[i].be, tbl[i].gv});
        end
        chk("vec_count", 64'(guess_count), 64'd1);

        // Slots 2,3,4,5 then a stalled handshake.
        step(B_NONE, 1'b0, 1'b0, 12'd0, 1'b1);
        step(B_U, 1'b0, 1'b0, 12'd0, 1'b0);
        for (int s = 1; s < 4; s++) begin
            step(B_R, 1'b0, 1'b0, 12'd0, 1'b0);
            for (int k = 0; k < s + 1; k++) step(B_U, 1'b0, 1'b0, 12'd0, 1'b0);
        end
        chk("slots_2345", 64'(guess_code), 64'(12'o5432));
        step(B_SUB, 1'b0, 1'b0, 12'd0, 1'b0);
        chk("hs_valid0", 64'({guess_valid, guess_code}), 64'({1'b1, 12'o5432}));
        for (int k = 1; k < 4; k++) begin
            step(B_L | B_U, 1'b0, 1'b0, 12'd0, 1'b0);
            chk($sformatf("hs_valid%0d", k), 64'({guess_valid, guess_code}), 64'({1'b1, 12'o5432}));
        end
        step(B_NONE, 1'b1, 1'b0, 12'd0, 1'b0);
        chk("hs_accept", 64'({guess_valid, guess_count}), 64'({1'b0, 4'd1}));

        step(B_U, 1'b0, 1'b1, 12'o2210, 1'b0);
        chk("fb_hist", 64'({history_rgb3, history_rgb2, history_rgb1, history_rgb0}), 64'(12'o2210));
        chk("fb_edit", 64'({blink_enable, blink_led, guess_code, game_over}),
            64'({1'b1, 2'd0, 12'o5432, 1'b0}));

        step(B_NONE, 1'b0, 1'b1, 12'o7777, 1'b0);
        chk("stray_fb", 64'({history_rgb3, history_rgb2, history_rgb1, history_rgb0}), 64'(12'o2210));

        // Win, frozen outputs, new game.
        step(B_SUB, 1'b0, 1'b0, 12'd0, 1'b0);
        step(B_NONE, 1'b1, 1'b0, 12'd0, 1'b0);
        step(B_NONE, 1'b0, 1'b1, 12'o2222, 1'b0);
        chk("win", 64'({game_over, game_won, blink_enable, guess_count}), 64'({1'b1, 1'b1, 1'b0, 4'd2}));
        step(B_L | B_U | B_D, 1'b1, 1'b1, 12'o0000, 1'b0);
        chk("done_frozen", 64'({blink_led, guess_code, game_over, game_won, history_rgb0}),
            64'({2'd0, 12'o5432, 1'b1, 1'b1, 3'd2}));
        step(B_SUB, 1'b0, 1'b0, 12'd0, 1'b0);
        chk("new_game", dut_vec(),
            {30'd0, 1'b0, 12'o1111, 1'b1, 2'd0, 12'o0000, 4'd0, 1'b0, 1'b0});

        // Ten losing rounds.
        for (int r = 1; r <= MAXG; r++) begin
            step(B_SUB, 1'b0, 1'b0, 12'd0, 1'b0);
            step(B_NONE, 1'b1, 1'b0, 12'd0, 1'b0);
            step(B_NONE, 1'b0, 1'b1, 12'o0120, 1'b0);
            chk($sformatf("lose_r%0d", r), 64'({game_over, guess_count}), 64'({(r == MAXG), 4'(r)}));
        end
        chk("lose_final", 64'({game_over, game_won, blink_enable}), 64'({1'b1, 1'b0, 1'b0}));

        // Reset while offering a guess.
        step(B_NONE, 1'b0, 1'b0, 12'd0, 1'b1);
        step(B_SUB, 1'b0, 1'b0, 12'd0, 1'b0);
        chk("rst_pre", 64'(guess_valid), 64'd1);
        step(B_NONE, 1'b1, 1'b0, 12'd0, 1'b1);
        chk("rst_mid_hs", 64'({guess_valid, guess_count, blink_enable}), 64'({1'b0, 4'd0, 1'b1}));

        // Random play against the reference model.
        for (int n = 0; n < 4000; n++) begin
            logic [4:0]  b;
            logic [11:0] fb;
            b  = ($urandom_range(0, 2) == 0) ? 5'($urandom) : B_NONE;
            if (b[4] && $urandom_range(0, 3) != 0) b[4] = 1'b0;
            fb = ($urandom_range(0, 5) == 0) ? 12'o2222 : 12'($urandom);
            step(b, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), fb,
                 ($urandom_range(0, 299) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
